mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory stage of the pipelined RV32I core. It sits directly downstream of the decode-to-execute register and the execute datapath. It latches the execute-stage results, performs the load/store handshake with the data memory port, and steers byte lanes according to the address mode. It delivers registered results to writeback and raises a stall to the hazard unit while a memory access is outstanding.

## Interface
Parameters:
- WIDTH, 32, datapath width (only 32 supported)

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- RegWriteE  in  1  register write enable from execute
- ResultSrcE  in  1  1 = writeback selects load data, 0 = ALU result
- MemWriteE  in  1  1 = store, 0 = load (meaningful only when the access is enabled)
- AddrModeE  in  4  bit3 = no access, bit2 = unsigned load, bits[1:0] = size (00 byte, 01 half, 10 word)
- ALUResultE  in  WIDTH  effective address or ALU result
- WriteDataE  in  WIDTH  store data, already forwarded
- RdE  in  5  destination register
- PCPlus4E  in  WIDTH  link value
- mem_req  out  1  access request
- mem_we  out  1  write strobe
- mem_addr  out  WIDTH  word-aligned address (bits[1:0] = 0)
- mem_be  out  4  byte enables
- mem_wdata  out  WIDTH  lane-shifted store data
- mem_ack  in  1  access complete; read data is valid in the same cycle
- mem_rdata  in  WIDTH  raw read word
- stallM  out  1  freeze request to hazard unit (stalls F/D/E)
- misalignedM  out  1  one-cycle pulse when a misaligned access is dropped
- RegWriteW, ResultSrcW  out  1 each  to writeback
- ALUResultW, ReadDataW, PCPlus4W  out  WIDTH  to writeback
- RdW  out  5  to writeback

## Operation
- **M-register.** Captures all E inputs on each edge when stallM = 0. It holds its contents when stallM = 1.
- **Access enable.** access = !AddrModeM[3].
- **Misalignment.** A half access is misaligned when addr[0] = 1. A word access is misaligned when addr[1:0] ≠ 0.
  - No request is issued for a misaligned access.
  - misalignedM pulses during the M cycle.
  - RegWriteW is forced to 0 for that instruction.
- **FSM.** Two states, IDLE and WAIT.
  - IDLE: mem_req = access & aligned.
  - IDLE, request with mem_ack = 1: the access completes and the state stays IDLE.
  - IDLE, request with mem_ack = 0: go to WAIT.
  - WAIT: mem_req held at 1 with mem_addr, mem_be, mem_we and mem_wdata stable. On mem_ack = 1, return to IDLE.
- **stallM** = mem_req & !mem_ack. It is combinational.
- **Store lanes.**
  - byte: be = 0001 << off; data replicated ×4.
  - half: be = 0011 << off; data replicated ×2.
  - word: be = 1111.
- **Load extraction.**
  - Select the byte or half at the offset.
  - Zero-extend if AddrMode[2] = 1, otherwise sign-extend.
  - A word load passes through unchanged.
- **W-register.**
  - Updates when stallM = 0.
  - While stallM = 1, a bubble is inserted: RegWriteW = 0 and RdW = 0.
  - ReadDataW = extracted load data for loads, 0 otherwise.

## Timing
- **Reset.**
  - All outputs 0; state IDLE.
  - The M-register resets to a bubble: RegWrite = 0, AddrMode = 4'b1000.
- **Reset mid-WAIT.** The request is abandoned immediately (asynchronous). No W write occurs.
- **Latency.**
  - Zero-wait memory: an instruction entering M at edge n reaches W at edge n+1. No stall.
  - N wait cycles: stallM high for N cycles. W is updated at the edge where mem_ack = 1.
- **Acknowledge rules.**
  - mem_ack while mem_req = 0 is ignored.
  - A second request is never issued before the ack.
- **Non-memory ops.** Pass through M to W with 1-cycle latency and never stall.

## Structure
- Package mem_pkg holds:
  - AddrMode field constants: MODE_NONE, MODE_UNSIGNED, SIZE_B/H/W.
  - FSM state enum.
  - Byte-enable patterns.
- Sub-module load_store_align: purely combinational.
  - Inputs: offset, size, unsigned flag, store data, read word.
  - Outputs: be, shifted wdata, extended load data, misaligned flag.
- The top level holds the M-register, the FSM and the W-register.

## Test plan
- **sw, immediate ack.** ALUResultE = 0x100, WriteDataE = 0xDEADBEEF, mem_ack tied high.
  - mem_addr = 0x100, be = 1111, wdata = 0xDEADBEEF.
  - stallM never asserted.
- **lb, two wait cycles.** Address 0x203, read word 0x80000000.
  - stallM high for 2 cycles.
  - ReadDataW = 0xFFFFFF80.
  - RegWriteW bubbles (0) during the wait.
- **lhu.** Address 0x42, read word 0xBEEF1234.
  - be = 1100, ReadDataW = 0x0000BEEF.
- **sb.** Address 0x11, data 0x000000AB.
  - be = 0010, wdata = 0xABABABAB.
- **Misaligned lw.** Address 0x106.
  - No mem_req; misalignedM pulses once; RegWriteW = 0.
  - The next instruction proceeds unstalled.
- **Reset mid-access.** Assert rst during WAIT.
  - mem_req drops immediately; all outputs 0; state IDLE.
  - After release, a non-memory op passes through with 1-cycle latency.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and types for the RV32I memory stage: AddrMode fields,
// byte-enable patterns, FSM states and the M-register layout.
package mem_pkg;

    localparam int XLEN = 32;

    localparam int         MODE_NONE     = 3;
    localparam int         MODE_UNSIGNED = 2;
    localparam logic [1:0] SIZE_B        = 2'b00;
    localparam logic [1:0] SIZE_H        = 2'b01;
    localparam logic [1:0] SIZE_W        = 2'b10;
    localparam logic [3:0] MODE_BUBBLE   = 4'b1000;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic            reg_write;
        logic            result_src;
        logic            mem_write;
        logic [3:0]      addr_mode;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc_plus4;
    } m_reg_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering: store byte enables and lane replication,
// load byte/half extraction with sign or zero extension, misalignment detect.
module load_store_align
    import mem_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        be_o         = BE_WORD;
        wdata_o      = wdata_i;
        load_o       = rdata_i;
        misaligned_o = 1'b0;
        case (size_i)
            SIZE_B: begin
                be_o    = BE_BYTE << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
                load_o  = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SIZE_H: begin
                be_o         = BE_HALF << offset_i;
                wdata_o      = {2{wdata_i[15:0]}};
                load_o       = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
                misaligned_o = offset_i[0];
            end
            default: begin
                // Size 2'b11 is not encoded by decode; it is handled like a word.
                misaligned_o = (offset_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I memory stage: M-register, load/store handshake FSM with the data
// memory port, byte-lane steering and the W-register feeding writeback.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteE,
    input  logic             ResultSrcE,
    input  logic             MemWriteE,
    input  logic [3:0]       AddrModeE,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic [4:0]       RdE,
    input  logic [WIDTH-1:0] PCPlus4E,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             stallM,
    output logic             misalignedM,
    output logic             RegWriteW,
    output logic             ResultSrcW,
    output logic [WIDTH-1:0] ALUResultW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [WIDTH-1:0] PCPlus4W,
    output logic [4:0]       RdW
);

    m_reg_t m_q, m_d;
    state_t state_q, state_d;

    logic             access;
    logic             misaligned;
    logic             is_load;
    logic [3:0]       be_raw;
    logic [WIDTH-1:0] wdata_raw;
    logic [WIDTH-1:0] load_data;

    logic             reg_write_w_q, result_src_w_q;
    logic [WIDTH-1:0] alu_result_w_q, read_data_w_q, pc_plus4_w_q;
    logic [4:0]       rd_w_q;

    // ---- M-register: holds while a memory access is outstanding
    always_comb begin
        m_d.reg_write  = RegWriteE;
        m_d.result_src = ResultSrcE;
        m_d.mem_write  = MemWriteE;
        m_d.addr_mode  = AddrModeE;
        m_d.alu_result = ALUResultE;
        m_d.write_data = WriteDataE;
        m_d.rd         = RdE;
        m_d.pc_plus4   = PCPlus4E;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q           <= '0;
            m_q.addr_mode <= MODE_BUBBLE;
        end else if (!stallM) begin
            m_q <= m_d;
        end
    end

    assign access  = !m_q.addr_mode[MODE_NONE];
    assign is_load = access && !m_q.mem_write;

    load_store_align u_align (
        .offset_i     (m_q.alu_result[1:0]),
        .size_i       (m_q.addr_mode[1:0]),
        .unsigned_i   (m_q.addr_mode[MODE_UNSIGNED]),
        .wdata_i      (m_q.write_data),
        .rdata_i      (mem_rdata),
        .be_o         (be_raw),
        .wdata_o      (wdata_raw),
        .load_o       (load_data),
        .misaligned_o (misaligned)
    );

    // ---- handshake FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem_req = access && !misaligned;
                if (mem_req && !mem_ack) state_d = S_WAIT;
            end
            S_WAIT: begin
                // M is frozen, so address/lanes/data stay stable until the ack.
                mem_req = 1'b1;
                if (mem_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign stallM      = mem_req && !mem_ack;
    assign misalignedM = access && misaligned;
    assign mem_we      = mem_req && m_q.mem_write;
    assign mem_addr    = {m_q.alu_result[WIDTH-1:2], 2'b00} & {WIDTH{mem_req}};
    assign mem_be      = be_raw & {4{mem_req}};
    assign mem_wdata   = wdata_raw & {WIDTH{mem_req}};

    // ---- W-register: bubble while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= 1'b0;
            alu_result_w_q <= '0;
            read_data_w_q  <= '0;
            pc_plus4_w_q   <= '0;
            rd_w_q         <= '0;
        end else if (!stallM) begin
            reg_write_w_q  <= m_q.reg_write && !misalignedM;
            result_src_w_q <= m_q.result_src;
            alu_result_w_q <= m_q.alu_result;
            read_data_w_q  <= (is_load && mem_req) ? load_data : '0;
            pc_plus4_w_q   <= m_q.pc_plus4;
            rd_w_q         <= m_q.rd;
        end else begin
            reg_write_w_q <= 1'b0;
            rd_w_q        <= '0;
        end
    end

    assign RegWriteW  = reg_write_w_q;
    assign ResultSrcW = result_src_w_q;
    assign ALUResultW = alu_result_w_q;
    assign ReadDataW  = read_data_w_q;
    assign PCPlus4W   = pc_plus4_w_q;
    assign RdW        = rd_w_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: each instruction pushes its expected
// W-register contents, popped when the DUT advances it into W.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ResultSrcE, MemWriteE;
    logic [3:0]  AddrModeE;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
    logic [4:0]  RdE;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stallM, misalignedM;
    logic        RegWriteW, ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rw;
        logic        rs;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    mem_access_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .AddrModeE(AddrModeE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .RdE(RdE), .PCPlus4E(PCPlus4E),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stallM(stallM), .misalignedM(misalignedM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference lane model written per byte lane.
    function automatic void model(input logic [3:0] mode, input logic [31:0] alu,
                                  input logic [31:0] wd, input logic [31:0] rdata,
                                  output logic req, output logic mis,
                                  output logic [3:0] be, output logic [31:0] wdata,
                                  output logic [31:0] ld);
        int nb, off;
        logic [31:0] sh;
        off = int'(alu[1:0]);
        nb  = (mode[1:0] == 2'b00) ? 1 : (mode[1:0] == 2'b01) ? 2 : 4;
        mis = !mode[3] && ((nb == 2 && (off % 2) != 0) || (nb == 4 && off != 0));
        req = !mode[3] && !mis;
        be  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nb) be[i] = 1'b1;
            wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        sh = rdata >> (8 * off);
        if (nb == 1)      ld = mode[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
        else if (nb == 2) ld = mode[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        else              ld = rdata;
    endfunction

    task automatic drive_bubble();
        RegWriteE = 1'b0; ResultSrcE = 1'b0; MemWriteE = 1'b0; AddrModeE = 4'b1000;
        ALUResultE = 32'h0; WriteDataE = 32'h0; RdE = 5'd0; PCPlus4E = 32'h0;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_RegWriteW"},  {31'h0, RegWriteW},  {31'h0, e.rw});
            chk({tag, "_ResultSrcW"}, {31'h0, ResultSrcW}, {31'h0, e.rs});
            chk({tag, "_ALUResultW"}, ALUResultW, e.alu);
            chk({tag, "_ReadDataW"},  ReadDataW,  e.rdata);
            chk({tag, "_PCPlus4W"},   PCPlus4W,   e.pc4);
            chk({tag, "_RdW"},        {27'h0, RdW}, {27'h0, e.rd});
        end
    endtask

    // Called just after a negedge; returns #1 after the edge that loads W.
    task automatic issue(input string tag, input logic rw, input logic rs, input logic mw,
                         input logic [3:0] mode, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] pc4, input int waits,
                         input logic [31:0] rdata);
        exp_t e;
        logic req, mis;
        logic [3:0] be;
        logic [31:0] wdata, ld;
        model(mode, alu, wd, rdata, req, mis, be, wdata, ld);
        e.rw = rw && !mis; e.rs = rs; e.alu = alu; e.pc4 = pc4; e.rd = rd;
        e.rdata = (req && !mw) ? ld : 32'h0;
        RegWriteE = rw; ResultSrcE = rs; MemWriteE = mw; AddrModeE = mode;
        ALUResultE = alu; WriteDataE = wd; RdE = rd; PCPlus4E = pc4;
        @(posedge clk);
        sb_q.push_back(e);
        #1;
        drive_bubble();
        if (req) begin
            mem_ack   = (waits == 0);
            mem_rdata = (waits == 0) ? rdata : 32'h5A5A5A5A;
        end else begin
            // An ack with no request outstanding must be ignored.
            mem_ack   = 1'b1;
            mem_rdata = 32'hA5A5A5A5;
        end
        @(negedge clk);
        chk({tag, "_mem_req"}, {31'h0, mem_req}, {31'h0, req});
        chk({tag, "_misalignedM"}, {31'h0, misalignedM}, {31'h0, mis});
        chk({tag, "_stallM"}, {31'h0, stallM}, {31'h0, req && waits > 0});
        if (req) begin
            chk({tag, "_mem_we"}, {31'h0, mem_we}, {31'h0, mw});
            chk({tag, "_mem_addr"}, mem_addr, {alu[31:2], 2'b00});
            chk({tag, "_mem_be"}, {28'h0, mem_be}, {28'h0, be});
            if (mw) chk({tag, "_mem_wdata"}, mem_wdata, wdata);
        end
        for (int k = 0; k < waits; k++) begin
            @(posedge clk);
            #1;
            if (k == waits - 1) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            @(negedge clk);
            chk({tag, "_stallM_wait"}, {31'h0, stallM}, {31'h0, k != waits - 1});
            chk({tag, "_mem_req_wait"}, {31'h0, mem_req}, 32'd1);
            chk({tag, "_mem_addr_wait"}, mem_addr, {alu[31:2], 2'b00});
            chk({tag, "_mem_be_wait"}, {28'h0, mem_be}, {28'h0, be});
            chk({tag, "_RegWriteW_bubble"}, {31'h0, RegWriteW}, 32'd0);
            chk({tag, "_RdW_bubble"}, {27'h0, RdW}, 32'd0);
        end
        @(posedge clk);
        #1;
        pop_check(tag);
        mem_ack = 1'b0;
        chk({tag, "_misalignedM_after"}, {31'h0, misalignedM}, 32'd0);
        chk({tag, "_mem_req_after"}, {31'h0, mem_req}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time budget exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        drive_bubble();
        @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'h0, mem_req}, 32'd0);
        chk("rst_stallM", {31'h0, stallM}, 32'd0);
        chk("rst_mem_be", {28'h0, mem_be}, 32'd0);
        chk("rst_RegWriteW", {31'h0, RegWriteW}, 32'd0);
        chk("rst_ALUResultW", ALUResultW, 32'd0);
        rst = 1'b0;

        //   tag    rw    rs    mw    mode     alu           wd            rd     pc4        waits rdata
        issue("sw",  1'b0, 1'b0, 1'b1, 4'b0010, 32'h0000_0100, 32'hDEADBEEF, 5'd0,  32'h1004, 0, 32'h0);
        issue("alu", 1'b1, 1'b0, 1'b0, 4'b1000, 32'h0000_1234, 32'h0,        5'd5,  32'h1008, 0, 32'h0);
        issue("lb",  1'b1, 1'b1, 1'b0, 4'b0000, 32'h0000_0203, 32'h0,        5'd7,  32'h100C, 2, 32'h8000_0000);
        issue("lhu", 1'b1, 1'b1, 1'b0, 4'b0101, 32'h0000_0042, 32'h0,        5'd8,  32'h1010, 0, 32'hBEEF_1234);
        issue("sb",  1'b0, 1'b0, 1'b1, 4'b0000, 32'h0000_0011, 32'h0000_00AB, 5'd0, 32'h1014, 0, 32'h0);
        issue("mlw", 1'b1, 1'b1, 1'b0, 4'b0010, 32'h0000_0106, 32'h0,        5'd9,  32'h1018, 0, 32'h0);
        issue("nxt", 1'b1, 1'b0, 1'b0, 4'b1000, 32'h0000_0077, 32'h0,        5'd10, 32'h101C, 0, 32'h0);
        issue("lh",  1'b1, 1'b1, 1'b0, 4'b0001, 32'h0000_0042, 32'h0,        5'd11, 32'h1020, 1, 32'h8001_5555);
        issue("sh",  1'b0, 1'b0, 1'b1, 4'b0001, 32'h0000_0302, 32'h0000_C0DE, 5'd0, 32'h1024, 3, 32'h0);
        issue("lw",  1'b1, 1'b1, 1'b0, 4'b0010, 32'h0000_0400, 32'h0,        5'd12, 32'h1028, 0, 32'h1234_5678);

        // Reset while a load is waiting for its acknowledge.
        @(negedge clk);
        RegWriteE = 1'b1; ResultSrcE = 1'b1; MemWriteE = 1'b0; AddrModeE = 4'b0010;
        ALUResultE = 32'h0000_0300; RdE = 5'd13; PCPlus4E = 32'h2000;
        @(posedge clk);
        #1;
        drive_bubble();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("rstw_stall_before", {31'h0, stallM}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rstw_mem_req", {31'h0, mem_req}, 32'd0);
        chk("rstw_stallM", {31'h0, stallM}, 32'd0);
        chk("rstw_mem_addr", mem_addr, 32'd0);
        chk("rstw_mem_be", {28'h0, mem_be}, 32'd0);
        chk("rstw_RegWriteW", {31'h0, RegWriteW}, 32'd0);
        chk("rstw_RdW", {27'h0, RdW}, 32'd0);
        chk("rstw_ReadDataW", ReadDataW, 32'd0);
        chk("rstw_PCPlus4W", PCPlus4W, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue("post", 1'b1, 1'b0, 1'b0, 4'b1000, 32'h0000_ABCD, 32'h0, 5'd14, 32'h2004, 0, 32'h0);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
